// File: rtl/simon_entry_checker.sv
// Simon game entry checker: synchronizes and debounces the player's button and nibble,
// then compares each press against the stored sequence and reports pass, fail or timeout.
module simon_entry_checker #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter int MAX_ROUNDS      = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [3:0] SW,
  input  logic       start,
  input  logic [5:0] round_len,
  output logic [5:0] exp_idx,
  input  logic [3:0] exp_nib,
  output logic       busy,
  output logic       entry_strobe,
  output logic       pass,
  output logic       fail,
  output logic [1:0] fail_code,
  output logic [5:0] entry_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]      MAX_LEN = 7'(MAX_ROUNDS);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_PRESS, WAIT_RELEASE} state_t;

  logic            btn_s1_q, btn_s2_q;
  logic [3:0]      sw_s1_q, sw_s2_q;
  logic            db_q, db_prev_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            armed_q;
  logic [DB_W-1:0] arm_cnt_q;
  logic            press;

  state_t          state_q;
  logic            busy_q, strobe_q, pass_q, fail_q, done_q;
  logic [1:0]      code_q;
  logic [5:0]      idx_q, cnt_q, len_q;
  logic [3:0]      nib_q;
  logic [TM_W-1:0] timer_q;
  logic            len_ok, last_entry;

  // Synchronizers, debouncer, and the post-reset arming guard
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q  <= 1'b0;
      btn_s2_q  <= 1'b0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      db_cnt_q  <= '0;
      armed_q   <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      sw_s1_q   <= SW;
      sw_s2_q   <= sw_s1_q;
      db_prev_q <= db_q;
      if (btn_s2_q != db_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_q     <= btn_s2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
      // A button held through reset must be seen released for a full debounce
      // interval before any rising edge counts as a press.
      if (!armed_q) begin
        if (!btn_s1_q && !btn_s2_q) begin
          if (arm_cnt_q == DB_LAST) armed_q <= 1'b1;
          else                      arm_cnt_q <= arm_cnt_q + 1'b1;
        end else begin
          arm_cnt_q <= '0;
        end
      end
    end
  end

  assign press      = db_q && !db_prev_q && armed_q;
  assign len_ok     = (round_len != 6'd0) && ({1'b0, round_len} <= MAX_LEN);
  assign last_entry = (cnt_q + 6'd1) == len_q;

  // Round length and expected nibble are plain data latches
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start && len_ok) len_q <= round_len;
    if (state_q == FETCH)                   nib_q <= exp_nib;
  end

  // Entry-phase FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      done_q   <= 1'b0;
      code_q   <= 2'b00;
      idx_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              idx_q   <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end else begin
              fail_q <= 1'b1;
              code_q <= 2'b11;
            end
          end
        end
        FETCH: begin
          timer_q <= '0;
          state_q <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          timer_q <= timer_q + 1'b1;
          if (press) begin
            state_q <= WAIT_RELEASE;
            if (sw_s2_q == nib_q) begin
              strobe_q <= 1'b1;
              cnt_q    <= cnt_q + 6'd1;
              if (last_entry) begin
                pass_q <= 1'b1;
                done_q <= 1'b1;
              end else begin
                idx_q  <= idx_q + 6'd1;
                done_q <= 1'b0;
              end
            end else begin
              fail_q <= 1'b1;
              code_q <= 2'b01;
              done_q <= 1'b1;
            end
          end else if (timer_q == TM_LAST) begin
            fail_q  <= 1'b1;
            code_q  <= 2'b10;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        WAIT_RELEASE: begin
          if (!db_q) begin
            if (done_q) begin
              // Parking the index at 0 gives storage a cycle to settle before the next FETCH.
              busy_q  <= 1'b0;
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign exp_idx      = idx_q;
  assign busy         = busy_q;
  assign entry_strobe = strobe_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign fail_code    = code_q;
  assign entry_count  = cnt_q;

endmodule
